// File: rtl/gfx_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : gfx_mem_arbiter
//  Description : Serves the four read-only graphics request ports (sprite
//                controller, BG0, BG1, overlay) from one shared pipelined
//                memory read port. A rotating-priority arbiter issues at most
//                one read per cycle, tags it with the owning port, and
//                returns the data with a one-cycle rready strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module gfx_mem_arbiter #(
    parameter int MEM_LATENCY = 1      // cycles from accepted read to mem_data (1..3)
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic [15:0] spcon_memory_address,
    input  logic        spcon_rvalid,
    output logic        spcon_rready,
    output logic [15:0] spcon_memory_data,

    input  logic [15:0] bg0_memory_address,
    input  logic        bg0_rvalid,
    output logic        bg0_rready,
    output logic [15:0] bg0_memory_data,

    input  logic [15:0] bg1_memory_address,
    input  logic        bg1_rvalid,
    output logic        bg1_rready,
    output logic [15:0] bg1_memory_data,

    input  logic [15:0] ov_memory_address,
    input  logic        ov_rvalid,
    output logic        ov_rready,
    output logic [15:0] ov_memory_data,

    output logic [15:0] mem_address,
    output logic        mem_rd,
    input  logic        mem_ready,
    input  logic [15:0] mem_data
);

    localparam int c_NUM_PORTS = 4;

    // Port index order: 0 = spcon, 1 = bg0, 2 = bg1, 3 = ov
    logic [3:0]                  w_req;
    logic [3:0][15:0]            w_addr;
    logic [3:0]                  w_elig;

    logic [3:0]                  r_pending;
    logic [1:0]                  r_rr_ptr;

    logic                        w_grant_vld;
    logic [1:0]                  w_grant_port;
    logic [1:0]                  w_idx;
    logic                        w_accept;
    logic [3:0]                  w_set;

    // Return-tag pipeline: stage MEM_LATENCY-1 lines up with valid mem_data
    logic [MEM_LATENCY-1:0]      r_tag_vld;
    logic [MEM_LATENCY-1:0][1:0] r_tag_port;
    logic                        w_ret_vld;
    logic [1:0]                  w_ret_port;

    logic [3:0]                  r_rready;
    logic [3:0][15:0]            r_data;

    assign w_req  = {ov_rvalid, bg1_rvalid, bg0_rvalid, spcon_rvalid};
    assign w_addr = {ov_memory_address, bg1_memory_address,
                     bg0_memory_address, spcon_memory_address};

    // A port with a read already in flight waits until its rready cycle ends
    assign w_elig = w_req & ~r_pending;

    // Rotating-priority search: start at r_rr_ptr, wrap 3 -> 0, first eligible wins
    always_comb begin
        w_grant_vld  = 1'b0;
        w_grant_port = 2'd0;
        w_idx        = 2'd0;
        for (int i = 0; i < c_NUM_PORTS; i++) begin
            w_idx = r_rr_ptr + 2'(i);
            if (!w_grant_vld && w_elig[w_idx]) begin
                w_grant_vld  = 1'b1;
                w_grant_port = w_idx;
            end
        end
    end

    // Request is suppressed during reset so memory never sees a read then
    assign mem_rd      = w_grant_vld & ~RST;
    assign mem_address = mem_rd ? w_addr[w_grant_port] : 16'h0000;
    assign w_accept    = mem_rd & mem_ready;
    assign w_set       = w_accept ? (4'b0001 << w_grant_port) : 4'b0000;

    assign w_ret_vld   = r_tag_vld[MEM_LATENCY-1];
    assign w_ret_port  = r_tag_port[MEM_LATENCY-1];

    // Arbitration state only moves on an accepted read; stalls leave it untouched
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rr_ptr  <= 2'd0;
            r_pending <= 4'b0000;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= w_grant_port + 2'd1;
            end
            r_pending <= (r_pending & ~r_rready) | w_set;
        end
    end

    // Shift the port tag alongside the memory pipeline
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tag_vld  <= '0;
            r_tag_port <= '0;
        end else begin
            r_tag_vld[0]  <= w_accept;
            r_tag_port[0] <= w_grant_port;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_port[i] <= r_tag_port[i-1];
            end
        end
    end

    // Capture returning data for the tagged port and strobe its rready for one cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rready <= 4'b0000;
            r_data   <= '0;
        end else begin
            r_rready <= 4'b0000;
            if (w_ret_vld) begin
                r_rready[w_ret_port] <= 1'b1;
                r_data[w_ret_port]   <= mem_data;
            end
        end
    end

    assign spcon_rready      = r_rready[0];
    assign bg0_rready        = r_rready[1];
    assign bg1_rready        = r_rready[2];
    assign ov_rready         = r_rready[3];
    assign spcon_memory_data = r_data[0];
    assign bg0_memory_data   = r_data[1];
    assign bg1_memory_data   = r_data[2];
    assign ov_memory_data    = r_data[3];

endmodule
`default_nettype wire

// File: tb/tb_gfx_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_gfx_mem_arbiter
//  Description : Self-checking bench for gfx_mem_arbiter. Three instances run
//                in lockstep with MEM_LATENCY = 1, 2, 3, each with its own
//                memory model. Accepted reads push the expected port/data
//                into a scoreboard that is checked on every rready strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gfx_mem_arbiter;

    localparam int c_NI = 3;   // instance k uses MEM_LATENCY = k+1

    logic              CLK = 1'b0;
    logic              RST;
    logic [3:0]        rv;
    logic [3:0][15:0]  addr;
    logic              mem_ready;

    logic [c_NI-1:0]             mem_rd_a;
    logic [c_NI-1:0][15:0]       mem_addr_a;
    logic [c_NI-1:0][15:0]       mem_data_a;
    logic [c_NI-1:0][3:0]        rready_a;
    logic [c_NI-1:0][3:0][15:0]  rdata_a;

    int n_chk  = 0;
    int n_fail = 0;

    // Scoreboard entry: {instance[1:0], port[1:0], data[15:0]}
    logic [19:0] sb_q[$];
    bit          rr_mode = 1'b0;
    int          rr_next [c_NI];
    int          rcnt    [c_NI][4];

    always #5 CLK = ~CLK;

    // Memory contents: fixed word for the single-read case, otherwise a byte swap
    function automatic logic [15:0] mem_lut(input logic [15:0] a);
        if (a == 16'h1234) return 16'hBEEF;
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    for (genvar k = 0; k < c_NI; k++) begin : g_dut
        logic [2:0][15:0] r_pipe;
        logic [2:0]       r_pvld = 3'b000;

        // Pipelined memory: data appears k+1 cycles after the accepting edge
        always @(posedge CLK) begin
            r_pvld[0]   <= mem_rd_a[k] & mem_ready;
            r_pipe[0]   <= mem_lut(mem_addr_a[k]);
            r_pvld[2:1] <= r_pvld[1:0];
            r_pipe[2:1] <= r_pipe[1:0];
        end
        assign mem_data_a[k] = r_pvld[k] ? r_pipe[k] : 16'hDEAD;

        gfx_mem_arbiter #(.MEM_LATENCY(k+1)) u_dut (
            .CLK                  (CLK),
            .RST                  (RST),
            .spcon_memory_address (addr[0]),
            .spcon_rvalid         (rv[0]),
            .spcon_rready         (rready_a[k][0]),
            .spcon_memory_data    (rdata_a[k][0]),
            .bg0_memory_address   (addr[1]),
            .bg0_rvalid           (rv[1]),
            .bg0_rready           (rready_a[k][1]),
            .bg0_memory_data      (rdata_a[k][1]),
            .bg1_memory_address   (addr[2]),
            .bg1_rvalid           (rv[2]),
            .bg1_rready           (rready_a[k][2]),
            .bg1_memory_data      (rdata_a[k][2]),
            .ov_memory_address    (addr[3]),
            .ov_rvalid            (rv[3]),
            .ov_rready            (rready_a[k][3]),
            .ov_memory_data       (rdata_a[k][3]),
            .mem_address          (mem_addr_a[k]),
            .mem_rd               (mem_rd_a[k]),
            .mem_ready            (mem_ready),
            .mem_data             (mem_data_a[k])
        );
    end

    // Monitor on the falling edge: pops the scoreboard on rready, pushes on accept
    always @(negedge CLK) begin
        int idx;
        int pm;
        if (RST) begin
            sb_q.delete();
            for (int k = 0; k < c_NI; k++) check("mem_rd_in_reset", mem_rd_a[k], 0);
        end else begin
            for (int k = 0; k < c_NI; k++) begin
                if (rready_a[k] != 4'b0000)
                    check("one_rready_per_cycle", ($countones(rready_a[k]) <= 1), 1);
                for (int p = 0; p < 4; p++) begin
                    if (rready_a[k][p]) begin
                        rcnt[k][p]++;
                        idx = -1;
                        foreach (sb_q[i]) if (idx < 0 && sb_q[i][19:18] == 2'(k)) idx = i;
                        check("sb_rready_expected", (idx >= 0), 1);
                        if (idx >= 0) begin
                            check("sb_port", p, sb_q[idx][17:16]);
                            check("sb_data", rdata_a[k][p], sb_q[idx][15:0]);
                            sb_q.delete(idx);
                        end
                    end
                end
                if (mem_rd_a[k] && mem_ready) begin
                    pm = -1;
                    for (int p = 0; p < 4; p++)
                        if (pm < 0 && rv[p] && addr[p] == mem_addr_a[k]) pm = p;
                    check("accept_port_legal", (pm >= 0), 1);
                    if (pm >= 0) begin
                        if (rr_mode) begin
                            check("rr_order", pm, rr_next[k]);
                            rr_next[k] = (pm + 1) % 4;
                        end
                        sb_q.push_back({2'(k), 2'(pm), mem_lut(addr[pm])});
                    end
                end
            end
        end
    end

    initial begin
        int mx;
        int mn;
        RST       = 1'b1;
        rv        = 4'h0;
        mem_ready = 1'b1;
        addr      = {16'h0300, 16'h0200, 16'h0100, 16'h1234};
        for (int k = 0; k < c_NI; k++) begin
            rr_next[k] = 0;
            for (int p = 0; p < 4; p++) rcnt[k][p] = 0;
        end
        repeat (2) step();

        // Reset: a request during reset must not reach memory
        rv = 4'hF;
        @(negedge CLK);
        for (int k = 0; k < c_NI; k++) check("rst_forces_mem_rd_low", mem_rd_a[k], 0);
        step();
        rv  = 4'h0;
        RST = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < c_NI; k++) begin
            check("rst_rready", rready_a[k], 0);
            check("idle_mem_rd", mem_rd_a[k], 0);
            check("idle_mem_addr", mem_addr_a[k], 0);
            for (int p = 0; p < 4; p++) check("rst_data", rdata_a[k][p], 0);
        end
        step();

        // Single read: spcon 0x1234 -> 0xBEEF, rready in cycle L+1 only
        rv[0] = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < c_NI; k++) begin
            check("single_mem_rd", mem_rd_a[k], 1);
            check("single_addr", mem_addr_a[k], 16'h1234);
        end
        step();
        rv[0] = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK);
            for (int k = 0; k < c_NI; k++) check("single_rready_timing", rready_a[k][0], (c == k + 2));
            step();
        end
        for (int k = 0; k < c_NI; k++) check("single_data_held", rdata_a[k][0], 16'hBEEF);
        check("single_sb_drained", sb_q.size(), 0);

        // Round robin from reset with all ports requesting continuously
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int k = 0; k < c_NI; k++) begin
            rr_next[k] = 0;
            for (int p = 0; p < 4; p++) rcnt[k][p] = 0;
        end
        addr    = {16'h4003, 16'h4002, 16'h4001, 16'h4000};
        rr_mode = 1'b1;
        rv      = 4'hF;
        repeat (32) step();
        rv      = 4'h0;
        rr_mode = 1'b0;
        repeat (6) step();
        for (int k = 0; k < c_NI; k++) begin
            mx = rcnt[k][0];
            mn = rcnt[k][0];
            for (int p = 1; p < 4; p++) begin
                if (rcnt[k][p] > mx) mx = rcnt[k][p];
                if (rcnt[k][p] < mn) mn = rcnt[k][p];
            end
            check("rr_no_starve", (mn >= 4), 1);
            check("rr_balanced", (mx - mn <= 1), 1);
        end
        check("rr_sb_drained", sb_q.size(), 0);

        // Stall: bg0 accept first leaves rr_ptr = 2, then bg1 and spcon wait on mem_ready
        rv[1] = 1'b1;
        step();
        rv = 4'h0;
        repeat (6) step();
        for (int c = 0; c < 12; c++) begin
            mem_ready = (c >= 5);
            rv        = {1'b0, (c <= 5), 1'b0, (c <= 6)};
            @(negedge CLK);
            for (int k = 0; k < c_NI; k++) begin
                check("stall_mem_rd", mem_rd_a[k], (c <= 6));
                if (c <= 5) check("stall_winner_bg1", mem_addr_a[k], addr[2]);
                if (c == 6) check("stall_next_spcon", mem_addr_a[k], addr[0]);
                check("stall_bg1_rready", rready_a[k][2], (c == k + 7));
                check("stall_spcon_rready", rready_a[k][0], (c == k + 8));
            end
            step();
        end
        check("stall_sb_drained", sb_q.size(), 0);

        // Back-to-back: rr_ptr = 1, bg0 then ov on consecutive cycles
        for (int c = 0; c < 8; c++) begin
            mem_ready = 1'b1;
            rv        = {(c <= 1), 1'b0, (c == 0), 1'b0};
            @(negedge CLK);
            for (int k = 0; k < c_NI; k++) begin
                if (c == 0) check("b2b_first_bg0", mem_addr_a[k], addr[1]);
                if (c == 1) check("b2b_second_ov", mem_addr_a[k], addr[3]);
                check("b2b_bg0_rready", rready_a[k][1], (c == k + 2));
                check("b2b_ov_rready", rready_a[k][3], (c == k + 3));
            end
            step();
        end
        check("b2b_sb_drained", sb_q.size(), 0);

        // Withdraw before accept: no response
        for (int c = 0; c < 7; c++) begin
            mem_ready = (c != 0);
            rv        = {3'b000, 1'b0} | {2'b00, (c == 0), 1'b0};
            @(negedge CLK);
            for (int k = 0; k < c_NI; k++) begin
                if (c < 2) check("wd_mem_rd", mem_rd_a[k], (c == 0));
                check("wd_cancel_no_rready", rready_a[k][1], 0);
            end
            step();
        end
        // Withdraw after accept: response still delivered
        for (int c = 0; c < 7; c++) begin
            mem_ready = 1'b1;
            rv        = {2'b00, (c == 0), 1'b0};
            @(negedge CLK);
            for (int k = 0; k < c_NI; k++) check("wd_accepted_rready", rready_a[k][1], (c == k + 2));
            step();
        end
        check("wd_sb_drained", sb_q.size(), 0);

        // Reset mid-flight: bg1 accepted (rr_ptr -> 3), reset one cycle later
        rv[2] = 1'b1;
        step();
        rv  = 4'h0;
        RST = 1'b1;
        repeat (2) step();
        RST = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            for (int k = 0; k < c_NI; k++) begin
                check("rstmf_no_rready", rready_a[k], 0);
                for (int p = 0; p < 4; p++) check("rstmf_data_zero", rdata_a[k][p], 0);
            end
            step();
        end
        // Priority restarts at port 0: bg0 beats ov
        rv = 4'b1010;
        @(negedge CLK);
        for (int k = 0; k < c_NI; k++) begin
            check("rstmf_mem_rd", mem_rd_a[k], 1);
            check("rstmf_prio_port0", mem_addr_a[k], addr[1]);
        end
        step();
        rv = 4'h0;
        repeat (8) step();
        check("final_sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
